// File: rtl/display_source_scheduler_if.sv
// Request/display bundle between the value sources and the display source scheduler.
// The master side raises requests and watches the display; the scheduler is the slave.
interface display_source_scheduler_if #(
  parameter int unsigned BIN_WIDTH = 14
);
  logic [3:0]             src_valid;
  logic [4*BIN_WIDTH-1:0] src_value;
  logic [3:0]             src_ready;
  logic [15:0]            bcd_out;
  logic                   bcd_valid;
  logic [1:0]             cur_src;
  logic                   overflow;

  modport master (
    output src_valid, src_value,
    input  src_ready, bcd_out, bcd_valid, cur_src, overflow
  );

  modport slave (
    input  src_valid, src_value,
    output src_ready, bcd_out, bcd_valid, cur_src, overflow
  );
endinterface

// File: rtl/display_source_scheduler.sv
// Round-robin sharing of a 4-digit BCD display among four binary sources, with a
// sequential double-dabble converter and a fixed dwell time per shown value.
module display_source_scheduler #(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DWELL_MAX = 49_999_999,
  parameter int unsigned DWELL_W   = 26
) (
  input logic                     clk,
  input logic                     rst_n,
  display_source_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [2:0] {
    ARB,
    GRANT,
    CONV,
    LOAD,
    SHOW
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           rr_ptr;      // next index to search from
  logic [1:0]           grant_idx;
  logic [3:0]           ready_r;
  logic [15:0]          bcd_sh;
  logic [BIN_WIDTH-1:0] bin_sh;
  logic                 ovf_flag;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DWELL_W-1:0]   dwell;
  logic [15:0]          bcd_out_r;
  logic                 bcd_valid_r;
  logic [1:0]           cur_src_r;
  logic                 overflow_r;

  logic                 found;
  logic [1:0]           pick;
  logic [1:0]           idx;
  logic [BIN_WIDTH-1:0] sel_value;
  logic [15+BIN_WIDTH:0] dd_next;

  // Add 3 to every BCD digit that is 5 or more, ahead of the shift.
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int d = 0; d < 4; d++) begin
      if (b[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && bus.src_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign sel_value = bus.src_value[grant_idx*BIN_WIDTH +: BIN_WIDTH];
  assign dd_next   = {add3(bcd_sh), bin_sh} << 1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:   if (found) state_nxt = GRANT;
      GRANT: state_nxt = CONV;
      CONV:  if (bit_cnt == CNT_W'(BIN_WIDTH - 1)) state_nxt = LOAD;
      LOAD:  state_nxt = SHOW;
      SHOW:  if (dwell == DWELL_W'(DWELL_MAX)) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= 2'd0;
      grant_idx   <= 2'd0;
      ready_r     <= 4'b0000;
      bcd_sh      <= 16'h0000;
      bin_sh      <= '0;
      ovf_flag    <= 1'b0;
      bit_cnt     <= '0;
      dwell       <= '0;
      bcd_out_r   <= 16'h0000;
      bcd_valid_r <= 1'b0;
      cur_src_r   <= 2'd0;
      overflow_r  <= 1'b0;
    end else begin
      ready_r <= 4'b0000;
      unique case (state)
        ARB: begin
          // READY is registered, so it is high exactly during the GRANT cycle.
          if (found) begin
            ready_r   <= 4'b0001 << pick;
            grant_idx <= pick;
            rr_ptr    <= pick + 2'd1;
          end
        end
        GRANT: begin
          bin_sh   <= sel_value;
          bcd_sh   <= 16'h0000;
          ovf_flag <= (32'(sel_value) > 32'd9999);
          bit_cnt  <= '0;
        end
        CONV: begin
          if (!ovf_flag) {bcd_sh, bin_sh} <= dd_next;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        LOAD: begin
          bcd_out_r   <= ovf_flag ? 16'h9999 : bcd_sh;
          cur_src_r   <= grant_idx;
          overflow_r  <= ovf_flag;
          bcd_valid_r <= 1'b1;
          dwell       <= '0;
        end
        SHOW: dwell <= dwell + DWELL_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.src_ready = ready_r;
  assign bus.bcd_out   = bcd_out_r;
  assign bus.bcd_valid = bcd_valid_r;
  assign bus.cur_src   = cur_src_r;
  assign bus.overflow  = overflow_r;

endmodule
